// File: rtl/seq_divider_16x8_if.sv
// Request/result bundle for the 16x8 sequential divider.
// Build with DIV_SIGNED_EN to add the signed_op request bit.
interface seq_divider_16x8_if #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
`ifdef DIV_SIGNED_EN
  logic                  signed_op;
`endif
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  done;
  logic                  busy;
  logic                  div_by_zero;
  logic                  err;
  logic [2:0]            state_out;

  modport master (
    output start, dividend, divisor,
`ifdef DIV_SIGNED_EN
    output signed_op,
`endif
    input  quotient, remainder, done, busy, div_by_zero, err, state_out
  );

  modport slave (
    input  start, dividend, divisor,
`ifdef DIV_SIGNED_EN
    input  signed_op,
`endif
    output quotient, remainder, done, busy, div_by_zero, err, state_out
  );
endinterface

// File: rtl/seq_divider_16x8.sv
// Restoring divider, one quotient bit per clock; start/done/state_out/err handshake.
// Define DIV_SIGNED_EN to add two's-complement operands and a one-cycle FIX state.
module seq_divider_16x8 #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic               clk,
  input  logic               reset_a,
  seq_divider_16x8_if.slave  bus
);
  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_CALC = 3'b010,
    S_FIX  = 3'b011,
    S_DONE = 3'b100,
    S_ERR  = 3'b101
  } state_e;

  state_e                state_q, state_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W:0]    part_q, part_d;
  logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
  logic                  sop_q, sop_d;
  logic                  negq_q, negq_d;
  logic                  negr_q, negr_d;
`endif

  logic [DIVISOR_W+1:0]  trial_s;
  logic [DIVISOR_W:0]    shifted_s, part_step_s;
  logic                  qbit_s;
  logic [DIVIDEND_W-1:0] quot_step_s, dvd_mag_s;
  logic [DIVISOR_W-1:0]  dvs_mag_s;

  // One restoring step; part_q[DIVISOR_W] is always 0 so the wide trial equals T.
  always_comb begin
    shifted_s   = {part_q[DIVISOR_W-1:0], quot_q[DIVIDEND_W-1]};
    trial_s     = {part_q, quot_q[DIVIDEND_W-1]} - {2'b00, dvsr_q};
    qbit_s      = ~trial_s[DIVISOR_W+1];
    part_step_s = qbit_s ? trial_s[DIVISOR_W:0] : shifted_s;
    quot_step_s = {quot_q[DIVIDEND_W-2:0], qbit_s};
  end

  // Operand magnitudes fed to the unsigned core.
  always_comb begin
    dvd_mag_s = bus.dividend;
    dvs_mag_s = bus.divisor;
`ifdef DIV_SIGNED_EN
    if (bus.signed_op && bus.dividend[DIVIDEND_W-1]) begin
      dvd_mag_s = -bus.dividend;
    end else begin
      dvd_mag_s = bus.dividend;
    end
    if (bus.signed_op && bus.divisor[DIVISOR_W-1]) begin
      dvs_mag_s = -bus.divisor;
    end else begin
      dvs_mag_s = bus.divisor;
    end
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    quot_d      = quot_q;
    part_d      = part_q;
    dvsr_d      = dvsr_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
    sop_d       = sop_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          if (bus.divisor == {DIVISOR_W{1'b0}}) begin
            quotient_d  = {DIVIDEND_W{1'b1}};
            remainder_d = bus.dividend[DIVISOR_W-1:0];
            dbz_d       = 1'b1;
            state_d     = S_DONE;
          end else begin
            quot_d  = dvd_mag_s;
            part_d  = {(DIVISOR_W+1){1'b0}};
            dvsr_d  = dvs_mag_s;
            cnt_d   = {CNT_W{1'b0}};
            dbz_d   = 1'b0;
            state_d = S_CALC;
`ifdef DIV_SIGNED_EN
            sop_d  = bus.signed_op;
            negq_d = bus.signed_op & (bus.dividend[DIVIDEND_W-1] ^ bus.divisor[DIVISOR_W-1]);
            negr_d = bus.signed_op & bus.dividend[DIVIDEND_W-1];
`endif
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      S_CALC: begin
        if (bus.start) begin
          quotient_d  = {DIVIDEND_W{1'b0}};
          remainder_d = {DIVISOR_W{1'b0}};
          state_d     = S_ERR;
        end else begin
          quot_d = quot_step_s;
          part_d = part_step_s;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
`ifdef DIV_SIGNED_EN
            if (sop_q) begin
              state_d = S_FIX;
            end else begin
              quotient_d  = quot_step_s;
              remainder_d = part_step_s[DIVISOR_W-1:0];
              state_d     = S_DONE;
            end
`else
            quotient_d  = quot_step_s;
            remainder_d = part_step_s[DIVISOR_W-1:0];
            state_d     = S_DONE;
`endif
          end else begin
            state_d = S_CALC;
          end
        end
      end
`ifdef DIV_SIGNED_EN
      S_FIX: begin
        if (bus.start) begin
          quotient_d  = {DIVIDEND_W{1'b0}};
          remainder_d = {DIVISOR_W{1'b0}};
          state_d     = S_ERR;
        end else begin
          quotient_d  = negq_q ? -quot_q : quot_q;
          remainder_d = negr_q ? -part_q[DIVISOR_W-1:0] : part_q[DIVISOR_W-1:0];
          state_d     = S_DONE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state_q     <= S_IDLE;
      quot_q      <= {DIVIDEND_W{1'b0}};
      part_q      <= {(DIVISOR_W+1){1'b0}};
      dvsr_q      <= {DIVISOR_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      quotient_q  <= {DIVIDEND_W{1'b0}};
      remainder_q <= {DIVISOR_W{1'b0}};
      dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
      sop_q       <= 1'b0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      quot_q      <= quot_d;
      part_q      <= part_d;
      dvsr_q      <= dvsr_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
      sop_q       <= sop_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
`endif
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.done        = (state_q == S_DONE);
  assign bus.busy        = (state_q == S_CALC) || (state_q == S_FIX);
  assign bus.err         = (state_q == S_ERR);
  assign bus.state_out   = state_q;
endmodule

// File: tb/tb_seq_divider_16x8.sv
// Scoreboard bench for seq_divider_16x8: directed operations push expected results,
// a negedge monitor pops and checks them whenever done is presented.
module tb_seq_divider_16x8;
  logic clk = 1'b0;
  logic reset_a = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];

  seq_divider_16x8_if bus();

  seq_divider_16x8 dut (
    .clk     (clk),
    .reset_a (reset_a),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (!reset_a) begin
      chk("busy_done_exclusive", {31'd0, bus.busy & bus.done}, 32'd0);
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", {16'd0, bus.quotient}, {16'd0, e.q});
          chk("remainder", {24'd0, bus.remainder}, {24'd0, e.r});
          chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
          chk("done_cycle", cyc, e.done_cyc);
          chk("state_done", {29'd0, bus.state_out}, 32'd4);
        end
      end
    end
  end

`ifdef DIV_SIGNED_EN
  logic sop_v = 1'b0;
`endif

  // Drive one request for a cycle; lat is the accept-to-done distance in edges.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                       input logic [7:0] er, input logic edbz, input int lat, input logic push);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
`ifdef DIV_SIGNED_EN
    bus.signed_op = sop_v;
`endif
    if (push) sb.push_back('{eq, er, edbz, cyc + 1 + lat});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_timeout", sb.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = 16'd0;
    bus.divisor  = 8'd0;
`ifdef DIV_SIGNED_EN
    bus.signed_op = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset_a = 1'b0;
    @(negedge clk);
    chk("rst_state", {29'd0, bus.state_out}, 32'd0);
    chk("rst_quotient", {16'd0, bus.quotient}, 32'd0);
    chk("rst_remainder", {24'd0, bus.remainder}, 32'd0);
    chk("rst_flags", {28'd0, bus.done, bus.busy, bus.div_by_zero, bus.err}, 32'd0);

    // 1000/7 with latency and state sequence
    do_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16, 1'b1);
    chk("t1_state_calc", {29'd0, bus.state_out}, 32'd2);
    chk("t1_busy", {31'd0, bus.busy}, 32'd1);
    drain();
    chk("t1_state_idle", {29'd0, bus.state_out}, 32'd0);

    do_op(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 16, 1'b1);
    drain();
    do_op(16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 16, 1'b1);
    drain();

    // divide by zero: no CALC cycles
    do_op(16'd1234, 8'd0, 16'hFFFF, 8'hD2, 1'b1, 0, 1'b1);
    chk("t3_no_busy", {31'd0, bus.busy}, 32'd0);
    drain();

    // abort on the 5th CALC cycle
    do_op(16'd1000, 8'd7, 16'd0, 8'd0, 1'b0, 0, 1'b0);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t4_state_err", {29'd0, bus.state_out}, 32'd5);
    chk("t4_err", {31'd0, bus.err}, 32'd1);
    chk("t4_q_zero", {16'd0, bus.quotient}, 32'd0);
    chk("t4_r_zero", {24'd0, bus.remainder}, 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_err_held", {29'd0, bus.state_out}, 32'd5);
    chk("t4_q_held", {16'd0, bus.quotient}, 32'd0);
    do_op(16'd100, 8'd10, 16'd10, 8'd0, 1'b0, 16, 1'b1);
    chk("t4_err_clear", {31'd0, bus.err}, 32'd0);
    drain();

    // back-to-back accept out of DONE
    do_op(16'd200, 8'd3, 16'd66, 8'd2, 1'b0, 16, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (bus.done) break;
      @(negedge clk);
    end
    chk("t5_done_seen", {31'd0, bus.done}, 32'd1);
    do_op(16'd50, 8'd5, 16'd10, 8'd0, 1'b0, 16, 1'b1);
    chk("t5_b2b_calc", {29'd0, bus.state_out}, 32'd2);
    drain();

    // asynchronous reset mid-CALC
    do_op(16'd1000, 8'd7, 16'd0, 8'd0, 1'b0, 0, 1'b0);
    repeat (5) @(negedge clk);
    reset_a = 1'b1;
    #1;
    chk("t5_arst_state", {29'd0, bus.state_out}, 32'd0);
    chk("t5_arst_q", {16'd0, bus.quotient}, 32'd0);
    chk("t5_arst_r", {24'd0, bus.remainder}, 32'd0);
    chk("t5_arst_flags", {28'd0, bus.done, bus.busy, bus.div_by_zero, bus.err}, 32'd0);
    @(negedge clk);
    reset_a = 1'b0;
    @(negedge clk);

`ifdef DIV_SIGNED_EN
    sop_v = 1'b1;
    do_op(16'hFF9C, 8'd7, 16'hFFF2, 8'hFE, 1'b0, 17, 1'b1);
    drain();
    do_op(16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0, 17, 1'b1);
    drain();
    sop_v = 1'b0;
    do_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16, 1'b1);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
